// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_pkg
// Description : Shared types and constants for the clock display path.
//               Holds the digit index type, the active-low 7-segment patterns
//               (bit order {g,f,e,d,c,b,a}) and the number of display digits.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

    typedef logic [2:0] digit_idx_t;

    localparam int unsigned c_num_digits = 6;

    // Active-low segment patterns, {g,f,e,d,c,b,a}
    localparam logic [6:0] c_seg_0    = 7'b1000000;
    localparam logic [6:0] c_seg_1    = 7'b1111001;
    localparam logic [6:0] c_seg_2    = 7'b0100100;
    localparam logic [6:0] c_seg_3    = 7'b0110000;
    localparam logic [6:0] c_seg_4    = 7'b0011001;
    localparam logic [6:0] c_seg_5    = 7'b0010010;
    localparam logic [6:0] c_seg_6    = 7'b0000010;
    localparam logic [6:0] c_seg_7    = 7'b1111000;
    localparam logic [6:0] c_seg_8    = 7'b0000000;
    localparam logic [6:0] c_seg_9    = 7'b0010000;
    localparam logic [6:0] c_seg_dash = 7'b0111111;
    localparam logic [6:0] c_seg_off  = 7'b1111111;

    // Codes 10..15 are not valid BCD and all render as a dash
    localparam logic [6:0] c_seg_a    = c_seg_dash;
    localparam logic [6:0] c_seg_b    = c_seg_dash;
    localparam logic [6:0] c_seg_c    = c_seg_dash;
    localparam logic [6:0] c_seg_d    = c_seg_dash;
    localparam logic [6:0] c_seg_e    = c_seg_dash;
    localparam logic [6:0] c_seg_f    = c_seg_dash;

endpackage : clock_pkg
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_7seg
// Description : Combinational BCD to active-low 7-segment decoder.
//               Invalid codes (10..15) decode to a dash.
// Ports       : i_bcd  [3:0] - BCD digit
//               o_seg  [6:0] - segments {g,f,e,d,c,b,a}, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_7seg
    import clock_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = c_seg_dash;
        case (i_bcd)
            4'd0:    o_seg = c_seg_0;
            4'd1:    o_seg = c_seg_1;
            4'd2:    o_seg = c_seg_2;
            4'd3:    o_seg = c_seg_3;
            4'd4:    o_seg = c_seg_4;
            4'd5:    o_seg = c_seg_5;
            4'd6:    o_seg = c_seg_6;
            4'd7:    o_seg = c_seg_7;
            4'd8:    o_seg = c_seg_8;
            4'd9:    o_seg = c_seg_9;
            4'd10:   o_seg = c_seg_a;
            4'd11:   o_seg = c_seg_b;
            4'd12:   o_seg = c_seg_c;
            4'd13:   o_seg = c_seg_d;
            4'd14:   o_seg = c_seg_e;
            default: o_seg = c_seg_f;
        endcase
    end

endmodule : bcd_to_7seg
`default_nettype wire

// File: rtl/display_scan_7seg.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_7seg
// Description : Multiplexed 6-digit common-anode 7-segment scanner for the
//               hh.mm.ss clock. One digit slot lasts CLK_HZ/SCAN_HZ cycles,
//               the first BLANK_CYCLES of each slot have every anode off to
//               suppress ghosting. All six digits are snapshotted at frame
//               start so one frame never mixes old and new time.
// Ports       : main_clock        - system clock
//               main_reset        - asynchronous, active-high reset
//               s_lsd/s_msd       - seconds units / tens (BCD)
//               m_lsd/m_msd       - minutes units / tens (BCD)
//               h_lsd/h_msd       - hours units / tens (BCD)
//               an   [5:0]        - digit enables, active-low, an[k] = slot k
//               seg  [6:0]        - segments {g,f,e,d,c,b,a}, active-low
//               dp                - decimal point, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_7seg
    import clock_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50000000,
    parameter int unsigned SCAN_HZ         = 1000,
    parameter int unsigned BLANK_CYCLES    = 2,
    parameter int unsigned BLANK_LEAD_ZERO = 1
) (
    input  logic       main_clock,
    input  logic       main_reset,
    input  logic [3:0] s_lsd,
    input  logic [2:0] s_msd,
    input  logic [3:0] m_lsd,
    input  logic [2:0] m_msd,
    input  logic [3:0] h_lsd,
    input  logic [2:0] h_msd,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned     c_div      = CLK_HZ / SCAN_HZ;
    localparam int unsigned     c_cnt_w    = (c_div > 1) ? $clog2(c_div) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_div - 1);
    localparam digit_idx_t      c_last_idx = digit_idx_t'(c_num_digits - 1);

    // A slot must contain at least one lit cycle after its blanking interval
    generate
        if (c_div < BLANK_CYCLES + 1) begin : g_bad_timing
            $error("display_scan_7seg: CLK_HZ/SCAN_HZ must be >= BLANK_CYCLES+1");
        end
    endgenerate

    logic [c_cnt_w-1:0]               r_cnt;
    digit_idx_t                       r_idx;
    logic [c_num_digits-1:0][3:0]     r_snap;
    logic [5:0]                       r_an;
    logic [6:0]                       r_seg;
    logic                             r_dp;

    logic [3:0]                       w_digit;
    logic [6:0]                       w_dec_seg;
    logic                             w_blank;
    logic [5:0]                       w_an;
    logic [6:0]                       w_seg;
    logic                             w_dp;

    // ------------------------------------------------------------------
    // Prescaler, slot index and frame-start snapshot
    // ------------------------------------------------------------------
    always_ff @(posedge main_clock or posedge main_reset) begin
        if (main_reset) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_snap <= '0;
        end else begin
            if (r_cnt == c_cnt_last) begin
                r_cnt <= '0;
                r_idx <= (r_idx == c_last_idx) ? '0 : r_idx + 3'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Frame start: this also fires on the first edge after reset
            // release, so the first frame shows freshly sampled digits.
            if ((r_cnt == '0) && (r_idx == '0)) begin
                r_snap <= {{1'b0, h_msd}, h_lsd,
                           {1'b0, m_msd}, m_lsd,
                           {1'b0, s_msd}, s_lsd};
            end
        end
    end

    // ------------------------------------------------------------------
    // Current-slot digit select and decode
    // ------------------------------------------------------------------
    always_comb begin
        w_digit = r_snap[0];
        case (r_idx)
            3'd0:    w_digit = r_snap[0];
            3'd1:    w_digit = r_snap[1];
            3'd2:    w_digit = r_snap[2];
            3'd3:    w_digit = r_snap[3];
            3'd4:    w_digit = r_snap[4];
            3'd5:    w_digit = r_snap[5];
            default: w_digit = 4'd0;
        endcase
    end

    bcd_to_7seg u_dec (
        .i_bcd (w_digit),
        .o_seg (w_dec_seg)
    );

    generate
        if (BLANK_CYCLES > 0) begin : g_blank
            assign w_blank = (r_cnt < c_cnt_w'(BLANK_CYCLES));
        end else begin : g_no_blank
            assign w_blank = 1'b0;
        end
    endgenerate

    always_comb begin
        w_an  = '1;
        w_seg = c_seg_off;
        w_dp  = 1'b1;
        if (!w_blank) begin
            w_an  = ~(6'd1 << r_idx);
            w_seg = w_dec_seg;
            // Dark leading hours digit keeps its anode so slot timing and
            // brightness of the other digits are unaffected.
            if ((BLANK_LEAD_ZERO != 0) && (r_idx == c_last_idx) && (w_digit == 4'd0)) begin
                w_seg = c_seg_off;
            end
            // Separators after hours units and minutes units: hh.mm.ss
            w_dp  = !((r_idx == 3'd2) || (r_idx == 3'd4));
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge main_clock or posedge main_reset) begin
        if (main_reset) begin
            r_an  <= '1;
            r_seg <= c_seg_off;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an;
            r_seg <= w_seg;
            r_dp  <= w_dp;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule : display_scan_7seg
`default_nettype wire

// File: tb/tb_display_scan_7seg.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_7seg
// Description : Self-checking bench for display_scan_7seg. A frame-position
//               reference model pushes the expected display state each clock
//               into a queue; a monitor pops and compares on the falling edge.
//               Two instances differ only in leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_7seg;

    localparam int unsigned CLK_HZ  = 60;
    localparam int unsigned SCAN_HZ = 10;
    localparam int unsigned DIV     = CLK_HZ / SCAN_HZ;
    localparam int unsigned BLANK   = 1;
    localparam int unsigned FRAME   = 6 * DIV;

    localparam logic [6:0] REF_SEG [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] REF_DASH = 7'b0111111;
    localparam logic [6:0] REF_OFF  = 7'b1111111;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg_lz;
        logic [6:0] seg_nlz;
        logic       dp;
    } exp_t;

    logic       main_clock;
    logic       main_reset;
    logic [3:0] s_lsd, m_lsd, h_lsd;
    logic [2:0] s_msd, m_msd, h_msd;
    logic [5:0] an_lz,  an_nlz;
    logic [6:0] seg_lz, seg_nlz;
    logic       dp_lz,  dp_nlz;

    int unsigned n_pass;
    int unsigned n_total;
    exp_t        q[$];
    int unsigned t;
    logic [3:0]  m_snap [6];

    display_scan_7seg #(
        .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLANK_CYCLES(BLANK), .BLANK_LEAD_ZERO(1)
    ) u_dut (
        .main_clock(main_clock), .main_reset(main_reset),
        .s_lsd(s_lsd), .s_msd(s_msd), .m_lsd(m_lsd), .m_msd(m_msd),
        .h_lsd(h_lsd), .h_msd(h_msd),
        .an(an_lz), .seg(seg_lz), .dp(dp_lz)
    );

    display_scan_7seg #(
        .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLANK_CYCLES(BLANK), .BLANK_LEAD_ZERO(0)
    ) u_dut_nlz (
        .main_clock(main_clock), .main_reset(main_reset),
        .s_lsd(s_lsd), .s_msd(s_msd), .m_lsd(m_lsd), .m_msd(m_msd),
        .h_lsd(h_lsd), .h_msd(h_msd),
        .an(an_nlz), .seg(seg_nlz), .dp(dp_nlz)
    );

    initial main_clock = 1'b0;
    always #5 main_clock = ~main_clock;

    function automatic logic [6:0] ref_decode(input logic [3:0] d);
        if (d > 4'd9) return REF_DASH;
        return REF_SEG[d];
    endfunction

    function automatic exp_t off_state();
        exp_t e;
        e.an      = 6'b111111;
        e.seg_lz  = REF_OFF;
        e.seg_nlz = REF_OFF;
        e.dp      = 1'b1;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    endtask

    // Reference model: t counts clock edges since reset release. The display
    // state seen at edge t is position p in a 6*DIV frame; digits shown come
    // from inputs taken at the most recent earlier frame start.
    always @(posedge main_clock) begin
        exp_t        e;
        int unsigned p, slot, c;
        if (main_reset) begin
            t = 0;
            e = off_state();
        end else begin
            p    = t % FRAME;
            slot = p / DIV;
            c    = p % DIV;
            e    = off_state();
            if (c >= BLANK) begin
                e.an      = 6'b111111 & ~(6'd1 << slot);
                e.seg_nlz = ref_decode(m_snap[slot]);
                e.seg_lz  = (slot == 5 && m_snap[5] == 4'd0) ? REF_OFF : e.seg_nlz;
                e.dp      = (slot == 2 || slot == 4) ? 1'b0 : 1'b1;
            end
            if (p == 0) begin
                m_snap[0] = s_lsd;
                m_snap[1] = {1'b0, s_msd};
                m_snap[2] = m_lsd;
                m_snap[3] = {1'b0, m_msd};
                m_snap[4] = h_lsd;
                m_snap[5] = {1'b0, h_msd};
            end
            t++;
        end
        q.push_back(e);
    end

    // Monitor: one expected entry per clock, compared mid-cycle
    always @(negedge main_clock) begin
        exp_t e;
        if (q.size() == 0) begin
            check("queue_underflow", 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            if (main_reset) e = off_state();
            check("disp_lz",  {an_lz,  seg_lz,  dp_lz},  {e.an, e.seg_lz,  e.dp});
            check("disp_nlz", {an_nlz, seg_nlz, dp_nlz}, {e.an, e.seg_nlz, e.dp});
            check("an_onehot", 32'($countones(~an_lz) <= 1), 32'd1);
        end
    end

    task automatic set_time(input logic [2:0] hm, input logic [3:0] hl,
                            input logic [2:0] mm, input logic [3:0] ml,
                            input logic [2:0] sm, input logic [3:0] sl);
        h_msd = hm; h_lsd = hl; m_msd = mm; m_lsd = ml; s_msd = sm; s_lsd = sl;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge main_clock);
        #2;
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        t          = 0;
        main_reset = 1'b1;
        set_time(3'd1, 4'd2, 3'd3, 4'd4, 3'd5, 4'd6);
        #1;
        check("reset_outputs", {an_lz, seg_lz, dp_lz}, {6'b111111, REF_OFF, 1'b1});
        run(3);
        main_reset = 1'b0;

        // 12:34:56 for two frames, then seconds tick during slot 3
        run(2 * FRAME + 20);
        s_lsd = 4'd7;
        run(2 * FRAME);

        // Leading hours zero, then an invalid BCD units digit
        set_time(3'd0, 4'd9, 3'd5, 4'd9, 3'd5, 4'd8);
        run(2 * FRAME);
        s_lsd = 4'hA;
        run(2 * FRAME);

        // Asynchronous reset in the middle of slot 3
        main_reset = 1'b1;
        run(2);
        main_reset = 1'b0;
        run(20);
        main_reset = 1'b1;
        #1;
        check("async_reset_lz",  {an_lz,  seg_lz,  dp_lz},  {6'b111111, REF_OFF, 1'b1});
        check("async_reset_nlz", {an_nlz, seg_nlz, dp_nlz}, {6'b111111, REF_OFF, 1'b1});
        set_time(3'd2, 4'd3, 3'd0, 4'd1, 3'd4, 4'd2);
        run(2);
        main_reset = 1'b0;
        run(2 * FRAME);

        // Randomized digits changed at random points in the scan
        for (int i = 0; i < 40; i++) begin
            set_time(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                     3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                     3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            run(int'($urandom_range(1, 60)));
        end
        run(FRAME);

        @(negedge main_clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_display_scan_7seg
`default_nettype wire

// File: doc/display_scan_7seg.md
Name: display_scan_7seg

Overview:
- Downstream consumer of the clock's six BCD digit outputs: seconds, minutes and hours, each as an LSD/MSD pair.
- Drives one multiplexed 6-digit common-anode 7-segment display, one digit at a time, with a refresh prescaler and inter-digit blanking against ghosting.
- Snapshots all digits at frame start so a single frame never mixes old and new time.
- Sits at the top level, fed directly by the seconds, minutes and hours counters.

Parameters:
- CLK_HZ, 50000000: main_clock frequency.
- SCAN_HZ, 1000: per-digit slot rate. DIV = CLK_HZ/SCAN_HZ cycles per slot.
- BLANK_CYCLES, 2: cycles at the start of each slot with all anodes off. Elaboration error unless DIV >= BLANK_CYCLES+1.
- BLANK_LEAD_ZERO, 1: 1 = hours MSD of 0 is shown dark.

Ports:
- main_clock  in  1  system clock
- main_reset  in  1  asynchronous, active-high reset
- s_lsd  in  4  seconds units (BCD)
- s_msd  in  3  seconds tens
- m_lsd  in  4  minutes units
- m_msd  in  3  minutes tens
- h_lsd  in  4  hours units
- h_msd  in  3  hours tens
- an  out  6  digit enables, active-low; an[k] selects slot k
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

Behaviour:
- Slot map: 0=s_lsd (rightmost), 1=s_msd, 2=m_lsd, 3=m_msd, 4=h_lsd, 5=h_msd. 3-bit MSD inputs are zero-extended to 4 bits.
- State: prescaler cnt (0..DIV-1), slot index idx (0..5), six 4-bit snapshot registers.
- Reset (async, immediate): cnt=0, idx=0, snapshot=0, an=6'b111111, seg=7'b1111111, dp=1.
- Per cycle:
  - If cnt==DIV-1: cnt<=0 and idx<=(idx==5)?0:idx+1. Otherwise cnt<=cnt+1.
- Snapshot:
  - All six inputs are captured on every edge where cnt==0 and idx==0, including the first edge after reset release.
  - Input changes at any other time are not visible until the next frame start.
- Outputs are registered and reflect state (cnt, idx, snapshot) from the previous cycle (1-cycle latency):
  - When cnt < BLANK_CYCLES: an=all 1, seg=all 1, dp=1.
  - Otherwise: an = ~(1<<idx), seg = decode(snapshot[idx]), dp = 0 when idx is 2 or 4 (hh.mm.ss separators), else 1.
- Decode (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 (invalid BCD) = dash 0111111
- Leading zero: if BLANK_LEAD_ZERO=1, idx==5 and snapshot h_msd==0, then seg=1111111. The anode is still driven so the slot timing is unchanged.
- Frame length is 6*DIV cycles. Each anode is low for DIV-BLANK_CYCLES consecutive cycles, and at most one anode is low at any time.
- Reset mid-slot: outputs go inactive immediately. The scan restarts at slot 0 with a fresh snapshot.

Decomposition:
- clock_pkg holds:
  - typedef digit_idx_t (logic [2:0])
  - SEG_* localparams for the 16 decode patterns, SEG_OFF, SEG_DASH
  - NUM_DIGITS=6
- One sub-module: bcd_to_7seg, combinational, 4-bit BCD in to 7-bit active-low segments, dash for invalid codes. It is reused by any future standalone display.

Test Plan (CLK_HZ=60, SCAN_HZ=10 so DIV=6, BLANK_CYCLES=1, unless stated):
1. Reset, then release with inputs 12:34:56 -> an pattern is 111111 for 1 cycle then 111110 for 5 cycles with seg=0000010 ('6'), dp=1. Slot 1: an=111101, seg=0010010 ('5'). Frame repeats every 36 cycles.
2. Run the full frame of 12:34:56 -> slot 2 seg=0011001 with dp=0; slot 4 seg=0100100 with dp=0; slot 5 seg=1111001. At no cycle is more than one bit of an low.
3. Change inputs from 12:34:56 to 12:34:57 during slot 3 -> slot 4/5 still show the old snapshot. Slot 0 of the next frame shows '7' (1111000).
4. h_msd=0, BLANK_LEAD_ZERO=1 -> slot 5 has an=011111 and seg=1111111. Re-run with BLANK_LEAD_ZERO=0 -> seg=1000000.
5. s_lsd=4'hA -> slot 0 seg=0111111 (dash).
6. Assert main_reset asynchronously mid-slot 3 -> an, seg, dp go to all 1 before the next edge. After release the scan restarts at slot 0 with newly sampled digits.
